// File: rtl/gesture_servo_driver_pkg.sv
// Shared constants, FSM state type and sizing helper for the gesture servo driver.
package gesture_servo_driver_pkg;

  localparam int NUM_FINGERS        = 8;
  localparam int DEF_PWM_PERIOD_CYC = 1_000_000;
  localparam int DEF_PULSE_MIN_CYC  = 50_000;
  localparam int DEF_PULSE_MAX_CYC  = 100_000;
  localparam int DEF_STEP_CYC       = 2_500;

  typedef enum logic {
    IDLE   = 1'b0,
    MOVING = 1'b1
  } state_t;

  // Bits needed to hold any value 0..max_val inclusive.
  function automatic int width_bits(input int max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/gesture_servo_driver_if.sv
// Gesture command in, PWM and status out; slave modport faces the driver.
interface gesture_servo_driver_if
  import gesture_servo_driver_pkg::*;
#(
  parameter int NUM_SERVO = NUM_FINGERS
);
  logic [NUM_SERVO-1:0] gesture;
  logic [NUM_SERVO-1:0] pwm;
  logic                 busy;
  logic                 done;
  logic                 dropped;

  modport master (output gesture, input pwm, input busy, input done, input dropped);
  modport slave  (input gesture, output pwm, output busy, output done, output dropped);
endinterface

// File: rtl/gesture_servo_driver_servo_pwm_channel.sv
// One servo: pulse-width register ramped toward its target once per frame,
// compared against the shared frame counter to produce a registered PWM bit.
module gesture_servo_driver_servo_pwm_channel #(
  parameter int FW            = 20,
  parameter int WW            = 17,
  parameter int PULSE_MIN_CYC = 50_000,
  parameter int PULSE_MAX_CYC = 100_000,
  parameter int STEP_CYC      = 2_500
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [FW-1:0] frame_cnt_i,
  input  logic          step_en_i,
  input  logic          target_i,
  output logic          pwm_o,
  output logic          at_target_o
);
  localparam int CW = (FW > WW) ? FW : WW;
  localparam logic [WW-1:0] W_MIN  = WW'(PULSE_MIN_CYC);
  localparam logic [WW-1:0] W_MAX  = WW'(PULSE_MAX_CYC);
  localparam logic [WW-1:0] W_STEP = WW'(STEP_CYC);

  logic [WW-1:0] width_q, width_d, stepped, tgt_w;
  logic          pwm_q;

  assign tgt_w = target_i ? W_MAX : W_MIN;

  // Clamp the last step so the width lands exactly on the target.
  always_comb begin
    stepped = width_q;
    if (width_q < tgt_w) begin
      stepped = ((tgt_w - width_q) <= W_STEP) ? tgt_w : (width_q + W_STEP);
    end else if (width_q > tgt_w) begin
      stepped = ((width_q - tgt_w) <= W_STEP) ? tgt_w : (width_q - W_STEP);
    end
    width_d = step_en_i ? stepped : width_q;
  end

  // Reflects the width as it will be after this frame's update.
  assign at_target_o = (stepped == tgt_w);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      width_q <= W_MIN;
      pwm_q   <= 1'b0;
    end else begin
      width_q <= width_d;
      pwm_q   <= (CW'(frame_cnt_i) < CW'(width_q));
    end
  end

  assign pwm_o = pwm_q;

endmodule

// File: rtl/gesture_servo_driver.sv
// Gesture-driven servo driver: frame counter, move FSM with one-deep pending
// buffer, and one PWM channel per servo.
module gesture_servo_driver
  import gesture_servo_driver_pkg::*;
#(
  parameter int NUM_SERVO      = NUM_FINGERS,
  parameter int PWM_PERIOD_CYC = DEF_PWM_PERIOD_CYC,
  parameter int PULSE_MIN_CYC  = DEF_PULSE_MIN_CYC,
  parameter int PULSE_MAX_CYC  = DEF_PULSE_MAX_CYC,
  parameter int STEP_CYC       = DEF_STEP_CYC
) (
  input  logic                    clk,
  input  logic                    rst_n,
  gesture_servo_driver_if.slave   bus
);
  localparam int FW = $clog2(PWM_PERIOD_CYC);
  localparam int WW = width_bits(PULSE_MAX_CYC);

  logic [FW-1:0]        frame_cnt_q;
  logic                 frame_end, step_en, all_at_target, gesture_vld;
  logic [NUM_SERVO-1:0] at_target, pwm_w;
  logic [NUM_SERVO-1:0] target_q, pend_q;
  logic                 pend_vld_q, busy_q, done_q, dropped_q;
  state_t               state_q;

  assign frame_end     = (frame_cnt_q == FW'(PWM_PERIOD_CYC - 1));
  assign step_en       = frame_end && (state_q == MOVING);
  assign all_at_target = &at_target;
  assign gesture_vld   = |bus.gesture;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
    end else if (frame_end) begin
      frame_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_q + FW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      target_q   <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dropped_q  <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      dropped_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (gesture_vld) begin
            target_q <= bus.gesture;
            state_q  <= MOVING;
            busy_q   <= 1'b1;
          end
        end
        MOVING: begin
          if (frame_end && all_at_target) begin
            done_q <= 1'b1;
            // A gesture arriving on the completion edge beats any queued one.
            if (gesture_vld) begin
              target_q   <= bus.gesture;
              dropped_q  <= pend_vld_q;
              pend_vld_q <= 1'b0;
            end else if (pend_vld_q) begin
              target_q   <= pend_q;
              pend_vld_q <= 1'b0;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end else if (gesture_vld) begin
            pend_q     <= bus.gesture;
            pend_vld_q <= 1'b1;
            dropped_q  <= pend_vld_q;
          end
        end
      endcase
    end
  end

  for (genvar i = 0; i < NUM_SERVO; i++) begin : gen_ch
    gesture_servo_driver_servo_pwm_channel #(
      .FW            (FW),
      .WW            (WW),
      .PULSE_MIN_CYC (PULSE_MIN_CYC),
      .PULSE_MAX_CYC (PULSE_MAX_CYC),
      .STEP_CYC      (STEP_CYC)
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .frame_cnt_i (frame_cnt_q),
      .step_en_i   (step_en),
      .target_i    (target_q[i]),
      .pwm_o       (pwm_w[i]),
      .at_target_o (at_target[i])
    );
  end

  assign bus.pwm     = pwm_w;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.dropped = dropped_q;

endmodule

// File: tb/tb_gesture_servo_driver.sv
// Scoreboard bench for gesture_servo_driver with a shortened PWM frame.
module tb_gesture_servo_driver;
  localparam int NS   = 8;
  localparam int P    = 100;
  localparam int WMIN = 20;
  localparam int WMAX = 40;
  localparam int STP  = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gesture_servo_driver_if #(.NUM_SERVO(NS)) bus ();

  gesture_servo_driver #(
    .NUM_SERVO      (NS),
    .PWM_PERIOD_CYC (P),
    .PULSE_MIN_CYC  (WMIN),
    .PULSE_MAX_CYC  (WMAX),
    .STEP_CYC       (STP)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int   cyc;
    logic done;
    logic drop;
  } ev_t;

  ev_t                   ev_q[$];
  logic [NS-1:0][7:0]    frame_q[$];

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int done_seen = 0;
  int drop_seen = 0;

  int         m_cnt;
  int         m_w[NS];
  int         hi[NS];
  logic [7:0] m_tgt, m_pend;
  logic       m_pvld, m_moving;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  task automatic model_reset();
    logic [NS-1:0][7:0] ew;
    m_cnt = 0;
    m_tgt = '0;
    m_pend = '0;
    m_pvld = 1'b0;
    m_moving = 1'b0;
    for (int i = 0; i < NS; i++) begin
      m_w[i] = WMIN;
      hi[i] = 0;
      ew[i] = 8'(WMIN);
    end
    frame_q.delete();
    ev_q.delete();
    frame_q.push_back(ew);
  endtask

  // Drive one cycle of gesture, advance the model across the edge, check outputs.
  task automatic step(input logic [7:0] g);
    logic               fe, all_at, e_done, e_drop;
    int                 nw[NS];
    int                 tw;
    logic [NS-1:0][7:0] ew;
    logic [1:0]         exp_ev;
    ev_t                ev;
    bus.gesture = g;
    @(posedge clk);
    fe = (m_cnt == P - 1);
    e_done = 1'b0;
    e_drop = 1'b0;
    all_at = 1'b1;
    for (int i = 0; i < NS; i++) begin
      tw = m_tgt[i] ? WMAX : WMIN;
      nw[i] = m_w[i];
      if (m_moving && fe) begin
        if (nw[i] < tw) nw[i] = (nw[i] + STP > tw) ? tw : nw[i] + STP;
        else if (nw[i] > tw) nw[i] = (nw[i] - STP < tw) ? tw : nw[i] - STP;
      end
      if (nw[i] != tw) all_at = 1'b0;
    end
    if (!m_moving) begin
      if (g != 0) begin
        m_tgt = g;
        m_moving = 1'b1;
      end
    end else if (fe && all_at) begin
      e_done = 1'b1;
      if (g != 0) begin
        m_tgt = g;
        e_drop = m_pvld;
        m_pvld = 1'b0;
      end else if (m_pvld) begin
        m_tgt = m_pend;
        m_pvld = 1'b0;
      end else begin
        m_moving = 1'b0;
      end
    end else if (g != 0) begin
      e_drop = m_pvld;
      m_pend = g;
      m_pvld = 1'b1;
    end
    for (int i = 0; i < NS; i++) begin
      m_w[i] = nw[i];
      ew[i] = 8'(nw[i]);
    end
    if (fe) frame_q.push_back(ew);
    m_cnt = fe ? 0 : m_cnt + 1;
    cyc++;
    if (e_done || e_drop) begin
      ev.cyc = cyc;
      ev.done = e_done;
      ev.drop = e_drop;
      ev_q.push_back(ev);
    end
    #1;
    for (int i = 0; i < NS; i++) hi[i] += int'(bus.pwm[i]);
    if (fe) begin
      if (frame_q.size() == 0) begin
        chk("frame_q_underflow", 64'd1, 64'd0);
      end else begin
        ew = frame_q.pop_front();
        for (int i = 0; i < NS; i++) begin
          chk($sformatf("width%0d", i), 64'(hi[i]), 64'(ew[i]));
          hi[i] = 0;
        end
      end
    end
    chk("busy", 64'(bus.busy), 64'(m_moving));
    if (bus.done || bus.dropped || (ev_q.size() > 0 && ev_q[0].cyc == cyc)) begin
      exp_ev = 2'b00;
      if (ev_q.size() > 0 && ev_q[0].cyc == cyc) begin
        ev = ev_q.pop_front();
        exp_ev = {ev.done, ev.drop};
      end
      chk("event_done_dropped", 64'({bus.done, bus.dropped}), 64'(exp_ev));
    end
    if (bus.done) done_seen++;
    if (bus.dropped) drop_seen++;
    @(negedge clk);
    bus.gesture = '0;
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) step(8'h00);
  endtask

  task automatic run_to(input int c);
    while (m_cnt != c) step(8'h00);
  endtask

  task automatic wait_idle(input int max_cyc);
    for (int k = 0; k < max_cyc && (m_moving || bus.busy); k++) step(8'h00);
    chk("idle_timeout", 64'(bus.busy), 64'd0);
  endtask

  // Assert reset between edges; outputs must clear without waiting for a clock.
  task automatic do_reset(input int hold);
    bus.gesture = '0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_pwm", 64'(bus.pwm), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_events", 64'({bus.done, bus.dropped}), 64'd0);
    repeat (hold) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    int d0, p0;
    logic pred;
    bus.gesture = '0;
    @(negedge clk);
    do_reset(3);

    // Idle after reset: every servo at the open width, no activity.
    idle_cycles(2 * P);

    // Single servo closes over four frames.
    idle_cycles(13);
    d0 = done_seen;
    step(8'h01);
    chk("s2_busy_next", 64'(bus.busy), 64'd1);
    wait_idle(6 * P);
    chk("s2_done_count", 64'(done_seen - d0), 64'd1);

    // Two gestures queued behind a move: the older is dropped.
    d0 = done_seen;
    p0 = drop_seen;
    step(8'h08);
    idle_cycles(30);
    step(8'h02);
    idle_cycles(40);
    step(8'h04);
    wait_idle(12 * P);
    chk("s3_drop_count", 64'(drop_seen - p0), 64'd1);
    chk("s3_done_count", 64'(done_seen - d0), 64'd2);

    // New gesture lands on the exact completing frame_end.
    step(8'h01);
    d0 = done_seen;
    for (int f = 0; f < 10; f++) begin
      run_to(P - 1);
      pred = m_moving;
      for (int i = 0; i < NS; i++) begin
        if ((m_w[i] - (m_tgt[i] ? WMAX : WMIN)) > STP ||
            ((m_tgt[i] ? WMAX : WMIN) - m_w[i]) > STP) pred = 1'b0;
      end
      if (pred) begin
        step(8'h80);
        break;
      end
      step(8'h00);
    end
    chk("s4_done_once", 64'(done_seen - d0), 64'd1);
    chk("s4_busy_held", 64'(bus.busy), 64'd1);
    wait_idle(8 * P);

    // Reset in the middle of a ramp.
    step(8'h01);
    run_to(P - 1);
    step(8'h00);
    run_to(P - 1);
    step(8'h00);
    idle_cycles(5);
    chk("s5_pre_pwm0", 64'(bus.pwm[0]), 64'd1);
    do_reset(2);
    idle_cycles(2 * P);

    // Zero gestures are not commands, neither idle nor mid-move.
    for (int k = 0; k < 20; k++) step(8'h00);
    chk("s6_idle", 64'(bus.busy), 64'd0);
    step(8'h10);
    idle_cycles(P);
    wait_idle(6 * P);

    chk("ev_q_empty", 64'(ev_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
